// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The master issues req/addr and holds them until the slave pulses rdy with data.
interface fetch_unit_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rdy;
   logic [15:0] imem_data;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdy,
      input  imem_data
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdy,
      output imem_data
   );
endinterface

// File: rtl/fetch_unit.sv
// WISC instruction-fetch stage: fetch PC, imem handshake, two-word output path
// (output register plus skid), branch redirect with wrong-path drain, and HLT stop.
module fetch_unit #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic                redirect_en,
   input  logic [15:0]         redirect_pc,
   fetch_unit_if.master        imem,
   output logic                if_valid,
   output logic [15:0]         if_instr,
   output logic [15:0]         if_pc,
   output logic                halted
);

   typedef enum logic [1:0] {StIdle, StWait, StDrain, StHalt} state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] req_addr_q, req_addr_d;
   logic        out_valid_q, out_valid_d;
   logic [15:0] out_instr_q, out_instr_d;
   logic [15:0] out_pc_q, out_pc_d;
   logic        skid_valid_q, skid_valid_d;
   logic [15:0] skid_instr_q, skid_instr_d;
   logic [15:0] skid_pc_q, skid_pc_d;

   logic        req;
   logic [15:0] fetch_addr;
   logic        capture;
   logic        consume;
   logic        halt_word;
   logic [15:0] redirect_target;

   assign redirect_target = redirect_pc & 16'hFFFE;
   assign halt_word       = (imem.imem_data[15:12] == HALT_OPCODE);
   assign consume         = out_valid_q && !stall;
   // Only responses to live requests are kept; drained and flushed ones are dropped.
   assign capture         = req && imem.imem_rdy && !redirect_en &&
                            (state_q == StIdle || state_q == StWait);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (redirect_en) begin
         state_d = ((state_q == StWait || state_q == StDrain) && !imem.imem_rdy) ? StDrain
                                                                                 : StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req && !imem.imem_rdy) state_d = StWait;
               else if (capture && halt_word) state_d = StHalt;
            end
            StWait: begin
               if (imem.imem_rdy) state_d = halt_word ? StHalt : StIdle;
            end
            StDrain: begin
               if (imem.imem_rdy) state_d = StIdle;
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      req        = 1'b0;
      fetch_addr = pc_q;
      halted     = 1'b0;
      unique case (state_q)
         StIdle:  req = !skid_valid_q && !redirect_en;
         StWait, StDrain: begin
            req        = 1'b1;
            fetch_addr = req_addr_q;
         end
         StHalt:  halted = 1'b1;
         default: req = 1'b0;
      endcase
      if (!rst_n) req = 1'b0;
   end

   assign imem.imem_req  = req;
   assign imem.imem_addr = fetch_addr;

   always_comb begin
      pc_d         = pc_q;
      req_addr_d   = req_addr_q;
      out_valid_d  = out_valid_q;
      out_instr_d  = out_instr_q;
      out_pc_d     = out_pc_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      if (redirect_en) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
         pc_d         = redirect_target;
      end else begin
         if (consume) begin
            if (skid_valid_q) begin
               out_instr_d  = skid_instr_q;
               out_pc_d     = skid_pc_q;
               skid_valid_d = 1'b0;
            end else begin
               out_valid_d = 1'b0;
            end
         end
         // A new word lands in whichever slot is free after this edge's consume.
         if (capture) begin
            if (!out_valid_d) begin
               out_valid_d = 1'b1;
               out_instr_d = imem.imem_data;
               out_pc_d    = fetch_addr;
            end else begin
               skid_valid_d = 1'b1;
               skid_instr_d = imem.imem_data;
               skid_pc_d    = fetch_addr;
            end
            pc_d = pc_q + 16'd2;
         end
         if (state_q == StIdle && req && !imem.imem_rdy) req_addr_d = pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         req_addr_q   <= RESET_PC;
         out_valid_q  <= 1'b0;
         out_instr_q  <= 16'h0000;
         out_pc_q     <= 16'h0000;
         skid_valid_q <= 1'b0;
         skid_instr_q <= 16'h0000;
         skid_pc_q    <= 16'h0000;
      end else begin
         pc_q         <= pc_d;
         req_addr_q   <= req_addr_d;
         out_valid_q  <= out_valid_d;
         out_instr_q  <= out_instr_d;
         out_pc_q     <= out_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
      end
   end

   assign if_valid = out_valid_q;
   assign if_instr = out_instr_q;
   assign if_pc    = out_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing scenarios plus a randomized run checked
// against a stream-level model of the expected instruction sequence.
module tb_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n       = 1'b0;
   logic        stall       = 1'b0;
   logic        redirect_en = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic        halted;

   int unsigned lat       = 0;
   int unsigned wcnt      = 0;
   logic        halt_en   = 1'b0;
   logic [15:0] halt_addr = 16'h0000;

   int vectors     = 0;
   int miscompares = 0;

   fetch_unit_if bus ();

   // Memory answers after `lat` wait cycles; data is addr^0x1000 unless it is the HLT slot.
   assign bus.imem_rdy  = bus.imem_req && (wcnt >= lat);
   assign bus.imem_data = (halt_en && bus.imem_addr == halt_addr) ? 16'hF000
                                                                   : (bus.imem_addr ^ 16'h1000);
   always @(posedge clk) begin
      if (!bus.imem_req || bus.imem_rdy) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end

   fetch_unit #(.RESET_PC(16'h0000), .HALT_OPCODE(4'hF)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .redirect_en (redirect_en),
      .redirect_pc (redirect_pc),
      .imem        (bus.master),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .halted      (halted)
   );

   // Second instance exercises the PC wrap from a top-of-memory reset address.
   logic        w_rst_n  = 1'b0;
   logic        w_zero   = 1'b0;
   logic [15:0] w_zero16 = 16'h0000;
   logic        w_valid;
   logic [15:0] w_instr;
   logic [15:0] w_pc;
   logic        w_halted;
   fetch_unit_if wbus ();
   assign wbus.imem_rdy  = wbus.imem_req;
   assign wbus.imem_data = wbus.imem_addr ^ 16'h1000;

   fetch_unit #(.RESET_PC(16'hFFFE), .HALT_OPCODE(4'hF)) u_wrap (
      .clk         (clk),
      .rst_n       (w_rst_n),
      .stall       (w_zero),
      .redirect_en (w_zero),
      .redirect_pc (w_zero16),
      .imem        (wbus.master),
      .if_valid    (w_valid),
      .if_instr    (w_instr),
      .if_pc       (w_pc),
      .halted      (w_halted)
   );

   // Outstanding request must keep req high and addr stable until rdy.
   logic        m_req = 1'b0;
   logic        m_rdy = 1'b0;
   logic        m_rst = 1'b0;
   logic [15:0] m_addr = 16'h0000;
   always @(negedge clk) begin
      #2;
      if (m_rst && rst_n && m_req && !m_rdy) begin
         vectors++;
         if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_addr) begin
            miscompares++;
            $display("FAIL req_hold t=%0t got req=%b addr=%h want req=1 addr=%h",
                     $time, bus.imem_req, bus.imem_addr, m_addr);
         end
      end
      m_req  = bus.imem_req;
      m_rdy  = bus.imem_rdy;
      m_addr = bus.imem_addr;
      m_rst  = rst_n;
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n       = 1'b0;
      stall       = 1'b0;
      redirect_en = 1'b0;
      redirect_pc = 16'h0000;
      @(posedge clk);
      @(posedge clk);
   endtask

   task automatic test_reset();
      lat = 0;
      halt_en = 1'b0;
      do_reset();
      @(negedge clk);
      #1;
      vectors++;
      if ({bus.imem_req, if_valid, halted} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_ctl got req=%b valid=%b halted=%b want 0 0 0",
                  bus.imem_req, if_valid, halted);
      end
      vectors++;
      if ({if_pc, if_instr, bus.imem_addr} !== 48'h0) begin
         miscompares++;
         $display("FAIL reset_data got pc=%h instr=%h addr=%h want 0 0 0",
                  if_pc, if_instr, bus.imem_addr);
      end
   endtask

   task automatic test_zero_wait();
      logic [15:0] e_pc;
      lat = 0;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         rst_n = 1'b1;
         #1;
         e_pc = (c > 0) ? 16'(2 * (c - 1)) : 16'h0000;
         vectors++;
         if ({bus.imem_req, bus.imem_addr, if_valid} !== {1'b1, 16'(2 * c), (c > 0)} ||
             (c > 0 && {if_pc, if_instr} !== {e_pc, e_pc ^ 16'h1000})) begin
            miscompares++;
            $display("FAIL zero_wait c=%0d got req=%b addr=%h v=%b pc=%h i=%h want addr=%h pc=%h",
                     c, bus.imem_req, bus.imem_addr, if_valid, if_pc, if_instr, 16'(2 * c), e_pc);
         end
      end
   endtask

   task automatic test_wait_states();
      logic        e_v;
      logic [15:0] e_pc;
      lat = 2;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         rst_n = 1'b1;
         #1;
         e_v  = (c % 3 == 0) && (c > 0);
         e_pc = (c >= 3) ? 16'(2 * (c / 3 - 1)) : 16'h0000;
         vectors++;
         if ({bus.imem_req, bus.imem_addr, if_valid} !== {1'b1, 16'(2 * (c / 3)), e_v} ||
             (e_v && {if_pc, if_instr} !== {e_pc, e_pc ^ 16'h1000})) begin
            miscompares++;
            $display("FAIL wait_states c=%0d got req=%b addr=%h v=%b pc=%h want addr=%h v=%b pc=%h",
                     c, bus.imem_req, bus.imem_addr, if_valid, if_pc, 16'(2 * (c / 3)), e_v, e_pc);
         end
      end
      lat = 0;
   endtask

   task automatic test_stall();
      logic e_req  [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      int   e_addr [9] = '{0, 2, 4, 4, 4, 4, 4, 6, 8};
      int   e_pc   [9] = '{0, 0, 0, 0, 0, 0, 2, 4, 6};
      lat = 0;
      do_reset();
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         rst_n = 1'b1;
         stall = (c < 5);
         #1;
         vectors++;
         if ({bus.imem_req, bus.imem_addr, if_valid} !== {e_req[c], 16'(e_addr[c]), (c > 0)} ||
             (c > 0 && {if_pc, if_instr} !== {16'(e_pc[c]), 16'(e_pc[c]) ^ 16'h1000})) begin
            miscompares++;
            $display("FAIL stall c=%0d got req=%b addr=%h v=%b pc=%h want req=%b addr=%h pc=%h",
                     c, bus.imem_req, bus.imem_addr, if_valid, if_pc, e_req[c], e_addr[c], e_pc[c]);
         end
      end
      stall = 1'b0;
   endtask

   task automatic test_redirect();
      int   s_lat [7] = '{0, 3, 3, 3, 0, 0, 0};
      logic s_stl [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic s_rd  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      int   e_addr[7] = '{0, 2, 2, 2, 2, 16'h40, 16'h42};
      logic e_v   [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      int   e_pc  [7] = '{0, 0, 0, 0, 0, 0, 16'h40};
      do_reset();
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         rst_n       = 1'b1;
         lat         = s_lat[c];
         stall       = s_stl[c];
         redirect_en = s_rd[c];
         redirect_pc = 16'h0041;
         #1;
         vectors++;
         if ({bus.imem_req, bus.imem_addr, if_valid} !== {1'b1, 16'(e_addr[c]), e_v[c]} ||
             (e_v[c] && {if_pc, if_instr} !== {16'(e_pc[c]), 16'(e_pc[c]) ^ 16'h1000})) begin
            miscompares++;
            $display("FAIL redirect c=%0d got req=%b addr=%h v=%b pc=%h want addr=%h v=%b pc=%h",
                     c, bus.imem_req, bus.imem_addr, if_valid, if_pc, e_addr[c], e_v[c], e_pc[c]);
         end
      end
      redirect_en = 1'b0;
      stall       = 1'b0;
   endtask

   task automatic test_halt();
      logic e_req [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      int   e_addr[11] = '{0, 2, 4, 6, 0, 0, 0, 0, 0, 16'h10, 16'h12};
      logic e_v   [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      int   e_pc  [11] = '{0, 0, 2, 4, 6, 0, 0, 0, 0, 0, 16'h10};
      logic e_h   [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [15:0] e_i;
      lat       = 0;
      halt_en   = 1'b1;
      halt_addr = 16'h0006;
      do_reset();
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         rst_n       = 1'b1;
         redirect_en = (c == 8);
         redirect_pc = 16'h0010;
         #1;
         e_i = (e_pc[c] == 6) ? 16'hF000 : (16'(e_pc[c]) ^ 16'h1000);
         vectors++;
         if ({bus.imem_req, if_valid, halted} !== {e_req[c], e_v[c], e_h[c]} ||
             (e_req[c] && bus.imem_addr !== 16'(e_addr[c])) ||
             (e_v[c] && {if_pc, if_instr} !== {16'(e_pc[c]), e_i})) begin
            miscompares++;
            $display("FAIL halt c=%0d got req=%b v=%b h=%b addr=%h pc=%h i=%h want %b %b %b %h %h %h",
                     c, bus.imem_req, if_valid, halted, bus.imem_addr, if_pc, if_instr,
                     e_req[c], e_v[c], e_h[c], e_addr[c], e_pc[c], e_i);
         end
      end
      redirect_en = 1'b0;
      halt_en     = 1'b0;
   endtask

   task automatic test_wrap();
      int e_addr [3] = '{16'hFFFE, 0, 2};
      int e_pc   [3] = '{0, 16'hFFFE, 0};
      @(negedge clk);
      w_rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         w_rst_n = 1'b1;
         #1;
         vectors++;
         if ({wbus.imem_addr, w_valid} !== {16'(e_addr[c]), (c > 0)} ||
             (c > 0 && {w_pc, w_instr} !== {16'(e_pc[c]), 16'(e_pc[c]) ^ 16'h1000})) begin
            miscompares++;
            $display("FAIL wrap c=%0d got addr=%h v=%b pc=%h i=%h want addr=%h pc=%h",
                     c, wbus.imem_addr, w_valid, w_pc, w_instr, e_addr[c], e_pc[c]);
         end
      end
      @(negedge clk);
      w_rst_n = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      lat = 0;
      do_reset();
      @(negedge clk);
      rst_n = 1'b1;
      stall = 1'b1;
      @(negedge clk);
      lat = 5;
      @(negedge clk);
      #1;
      vectors++;
      if ({bus.imem_req, bus.imem_addr, if_valid} !== {1'b1, 16'h0002, 1'b1}) begin
         miscompares++;
         $display("FAIL mid_wait_pre got req=%b addr=%h v=%b want 1 0002 1",
                  bus.imem_req, bus.imem_addr, if_valid);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++;
      if (bus.imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_wait_req got req=%b want 0", bus.imem_req);
      end
      @(negedge clk);
      #1;
      vectors++;
      if ({bus.imem_req, if_valid, halted, bus.imem_addr} !== {3'b000, 16'h0000}) begin
         miscompares++;
         $display("FAIL mid_wait_rst got req=%b v=%b h=%b addr=%h want 0 0 0 0000",
                  bus.imem_req, if_valid, halted, bus.imem_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      stall = 1'b0;
      lat   = 0;
      @(negedge clk);
      #1;
      vectors++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 16'h0000, 16'h1000}) begin
         miscompares++;
         $display("FAIL mid_wait_resume got v=%b pc=%h i=%h want 1 0000 1000",
                  if_valid, if_pc, if_instr);
      end
   endtask

   // Model: the consumed words form the sequence target, target+2, ... up to a HLT word.
   task automatic test_random();
      logic [15:0] exp_pc     = 16'h0000;
      logic [15:0] exp_word;
      logic        halt_seen  = 1'b0;
      logic        prev_redir = 1'b0;
      logic        prev_hold  = 1'b0;
      logic [15:0] prev_pc    = 16'h0000;
      logic [15:0] prev_instr = 16'h0000;
      int          delivered  = 0;
      halt_en   = 1'b1;
      halt_addr = 16'h0020;
      lat       = 0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst_n       = 1'b1;
         stall       = ($urandom_range(0, 3) == 0);
         lat         = $urandom_range(0, 2);
         redirect_en = ($urandom_range(0, 39) == 0);
         redirect_pc = 16'($urandom_range(0, 63));
         #1;
         exp_word = (exp_pc == halt_addr) ? 16'hF000 : (exp_pc ^ 16'h1000);
         if (prev_redir) begin
            vectors++;
            if ({if_valid, halted} !== 2'b00) begin
               miscompares++;
               $display("FAIL rnd_flush c=%0d got v=%b h=%b want 0 0", c, if_valid, halted);
            end
         end else if (prev_hold) begin
            vectors++;
            if ({if_valid, if_pc, if_instr} !== {1'b1, prev_pc, prev_instr}) begin
               miscompares++;
               $display("FAIL rnd_hold c=%0d got v=%b pc=%h i=%h want 1 %h %h",
                        c, if_valid, if_pc, if_instr, prev_pc, prev_instr);
            end
         end
         if (if_valid) begin
            vectors++;
            if (halt_seen || if_pc !== exp_pc || if_instr !== exp_word) begin
               miscompares++;
               $display("FAIL rnd_word c=%0d got pc=%h i=%h want pc=%h i=%h halted_before=%b",
                        c, if_pc, if_instr, exp_pc, exp_word, halt_seen);
            end
            if (if_instr[15:12] == 4'hF) begin
               vectors++;
               if (halted !== 1'b1) begin
                  miscompares++;
                  $display("FAIL rnd_hlt_flag c=%0d got halted=%b want 1", c, halted);
               end
            end
         end
         if (halt_seen) begin
            vectors++;
            if ({halted, bus.imem_req} !== 2'b10) begin
               miscompares++;
               $display("FAIL rnd_halted c=%0d got halted=%b req=%b want 1 0",
                        c, halted, bus.imem_req);
            end
         end
         prev_redir = redirect_en;
         prev_hold  = if_valid && stall && !redirect_en;
         prev_pc    = if_pc;
         prev_instr = if_instr;
         if (redirect_en) begin
            exp_pc    = redirect_pc & 16'hFFFE;
            halt_seen = 1'b0;
         end else if (if_valid && !stall) begin
            delivered++;
            if (exp_pc == halt_addr) halt_seen = 1'b1;
            exp_pc = exp_pc + 16'd2;
         end
      end
      vectors++;
      if (delivered < 200) begin
         miscompares++;
         $display("FAIL rnd_progress got %0d words want at least 200", delivered);
      end
      redirect_en = 1'b0;
      stall       = 1'b0;
      halt_en     = 1'b0;
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_stall();
      test_redirect();
      test_halt();
      test_wrap();
      test_reset_mid_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
